// File: rtl/mux_pkg.sv
// mux_pkg: shared defaults and an elaboration helper for the bit-select muxes.
//   N_IN_DEF  default number of selectable input bits
//   SEL_W_DEF default select width
//   sel_w(n)  ceil(log2(n)); used to validate SEL_W against N_IN at elaboration
package mux_pkg;

    localparam int N_IN_DEF  = 16;
    localparam int SEL_W_DEF = 4;

    function automatic int sel_w(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_tree.sv
// mux_tree: purely combinational binary tree of 2:1 muxes selecting in[sel].
//   in  [N_IN-1:0]  candidate bits
//   sel [SEL_W-1:0] unsigned index; level nearest the leaves uses sel[0]
//   y               selected bit (0 for indices past N_IN)
// The tree is stored heap-style in node[]: node k has children 2k+1 / 2k+2,
// leaves sit at node[P-1+i]. Leaves beyond N_IN are tied to 0 so that an
// out-of-range select naturally yields 0.
module mux_tree
    import mux_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [N_IN-1:0]  in,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    localparam int P = 1 << SEL_W;

    logic [2*P-2:0] node;

    // Leaves, zero-padded up to the next power of two.
    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < N_IN) begin : g_in
            assign node[P-1+i] = in[i];
        end else begin : g_pad
            assign node[P-1+i] = 1'b0;
        end
    end

    // Internal nodes: depth d is controlled by sel[SEL_W-1-d], so the root
    // resolves the MSB and the level just above the leaves resolves the LSB.
    // A ?: with a known select never lets X on the unpicked leg through.
    for (genvar d = 0; d < SEL_W; d++) begin : g_lvl
        for (genvar m = 0; m < (1 << d); m++) begin : g_node
            localparam int K = (1 << d) - 1 + m;
            assign node[K] = sel[SEL_W-1-d] ? node[2*K+2] : node[2*K+1];
        end
    end

    assign y = node[0];

endmodule

// File: rtl/mux16.sv
// mux16: registered single-bit selector, out <= in[sel] every rising clk.
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset, clears out
//   in    [N_IN-1:0] packed candidate bits
//   sel   [SEL_W-1:0] unsigned index
//   out   registered selected bit, one cycle latency
module mux16
    import mux_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in,
    input  logic [SEL_W-1:0] sel,
    output logic             out
);

    if (N_IN < 2 || SEL_W != sel_w(N_IN)) begin : g_bad_param
        $error("mux16: need N_IN >= 2 and SEL_W == ceil(log2(N_IN))");
    end

    logic sel_bit;

    mux_tree #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_tree (
        .in  (in),
        .sel (sel),
        .y   (sel_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out <= 1'b0;
        else        out <= sel_bit;
    end

endmodule

// File: tb/tb_mux16.sv
// tb_mux16: directed, table-driven check of mux16 plus hand-written
// sequences for reset, latency and mid-stream reset behaviour.
module tb_mux16;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic [3:0]  sel;
    logic        out;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [15:0] in;
        logic [3:0]  sel;
        logic        exp;
    } vec_t;

    vec_t vecs[$];

    mux16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .sel   (sel),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: out=%b expected %b", name, act, exp);
        end
    endtask

    task automatic tick_check(input string name, input logic exp);
        @(posedge clk);
        #1;
        check(name, out, exp);
    endtask

    initial begin
        vec_t v;
        logic [15:0] w;
        n_chk  = 0;
        n_fail = 0;

        // Basic selection on 16'h3F0A = 0011_1111_0000_1010.
        vecs.push_back('{16'h3F0A, 4'h0, 1'b0});
        vecs.push_back('{16'h3F0A, 4'h1, 1'b1});
        vecs.push_back('{16'h3F0A, 4'h6, 1'b0});
        vecs.push_back('{16'h3F0A, 4'hC, 1'b1});
        vecs.push_back('{16'h3F0A, 4'h3, 1'b1});
        vecs.push_back('{16'h3F0A, 4'hF, 1'b0});
        vecs.push_back('{16'h8000, 4'hF, 1'b1});
        vecs.push_back('{16'h7FFF, 4'hF, 1'b0});
        // Walking one: out=1 only where sel matches the set bit.
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < 16; s++) begin
                w = 16'h0001 << k;
                vecs.push_back('{w, 4'(s), (s == k)});
            end
        end

        // Reset held: out stays 0 across edges.
        rst_n = 1'b0;
        in    = 16'hFFFF;
        sel   = 4'h5;
        #1;
        check("reset_initial", out, 1'b0);
        tick_check("reset_hold_edge1", 1'b0);
        tick_check("reset_hold_edge2", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_no_edge", out, 1'b0);
        tick_check("reset_release_first_edge", 1'b1);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            in  = v.in;
            sel = v.sel;
            tick_check($sformatf("vec%0d_in%h_sel%h", i, v.in, v.sel), v.exp);
        end

        // Latency: in toggles each cycle with sel=F; out lags by one edge and
        // must not change before the edge.
        @(negedge clk);
        sel = 4'hF;
        in  = 16'h7FFF;
        tick_check("toggle_prime", 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
            #1;
            check($sformatf("toggle%0d_pre_edge", i), out, (i % 2 == 0) ? 1'b0 : 1'b1);
            tick_check($sformatf("toggle%0d_post_edge", i), (i % 2 == 0) ? 1'b1 : 1'b0);
        end

        // Simultaneous in/sel change picks new in at new sel.
        @(negedge clk);
        in  = 16'h0004;
        sel = 4'h2;
        tick_check("simul_change", 1'b1);

        // Mid-stream reset with in=FFFF and sel sweeping.
        in = 16'hFFFF;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            sel = 4'(s);
            tick_check($sformatf("midrst_pre_sel%0d", s), 1'b1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_async_drop", out, 1'b0);
        tick_check("midrst_hold", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sel   = 4'h9;
        #1;
        check("midrst_release_no_edge", out, 1'b0);
        tick_check("midrst_resume", 1'b1);

        // X isolation on unselected bits.
        @(negedge clk);
        in  = 16'hxxx1;
        sel = 4'h0;
        tick_check("x_isolation", 1'b1);
        n_chk++;
        if ($isunknown(out)) begin
            n_fail++;
            $display("FAIL x_known: out=%b expected known 1", out);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
